// File: rtl/mem_ctrl.sv
// Memory controller between the core's held-request memory port and a
// synchronous single-port SRAM, plus a small MMIO page (console, halt, cycle).
module mem_ctrl #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int unsigned RAM_WORDS   = 16384,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  core_addr,
  input  logic [31:0]                  core_wdata,
  input  logic                         core_read,
  input  logic                         core_write,
  output logic [31:0]                  core_rdata,
  output logic                         core_resp,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [$clog2(RAM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata,
  output logic                         console_valid,
  output logic [7:0]                   console_data,
  output logic                         halt,
  output logic [31:0]                  exit_code,
  output logic                         err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [2:0] {RG_RAM, RG_CONSOLE, RG_HALT, RG_CYCLE, RG_UNMAPPED} region_t;

  state_t         state_q;
  region_t        region_q;
  region_t        region_d;
  logic           write_q;
  logic           both_q;
  logic [31:0]    wdata_q;
  logic [AW-1:0]  ram_idx_q;
  logic [3:0]     wait_cnt_q;
  logic [31:0]    cycle_q;
  logic [31:0]    rdata_q;
  logic           resp_q;
  logic           sram_en_q;
  logic           sram_we_q;
  logic           console_valid_q;
  logic [7:0]     console_data_q;
  logic           halt_q;
  logic [31:0]    exit_code_q;
  logic           err_q;

  logic [31:0]    req_addr;
  logic [31:0]    ram_off;
  logic           unused_bits;

  // Byte-offset into the RAM window wraps at 32 bits, so addresses below
  // RAM_BASE land far out of range and decode as unmapped.
  always_comb begin
    req_addr = {core_addr[31:2], 2'b00};
    ram_off  = req_addr - {RAM_BASE[31:2], 2'b00};
    if ({2'b00, ram_off[31:2]} < RAM_WORDS) begin
      region_d = RG_RAM;
    end else if (req_addr == MMIO_BASE) begin
      region_d = RG_CONSOLE;
    end else if (req_addr == MMIO_BASE + 32'd4) begin
      region_d = RG_HALT;
    end else if (req_addr == MMIO_BASE + 32'd8) begin
      region_d = RG_CYCLE;
    end else begin
      region_d = RG_UNMAPPED;
    end
  end

  assign unused_bits = ^{core_addr[1:0], ram_off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      region_q        <= RG_RAM;
      write_q         <= 1'b0;
      both_q          <= 1'b0;
      wdata_q         <= '0;
      ram_idx_q       <= '0;
      wait_cnt_q      <= '0;
      cycle_q         <= '0;
      rdata_q         <= '0;
      resp_q          <= 1'b0;
      sram_en_q       <= 1'b0;
      sram_we_q       <= 1'b0;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      halt_q          <= 1'b0;
      exit_code_q     <= '0;
      err_q           <= 1'b0;
    end else begin
      cycle_q         <= cycle_q + 32'd1;
      resp_q          <= 1'b0;
      sram_en_q       <= 1'b0;
      sram_we_q       <= 1'b0;
      console_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (core_read || core_write) begin
            region_q  <= region_d;
            write_q   <= core_write;
            both_q    <= core_read && core_write;
            wdata_q   <= core_wdata;
            ram_idx_q <= ram_off[AW+1:2];
            if (region_d == RG_RAM) begin
              if (WAIT_STATES != 0) begin
                state_q    <= ST_WAIT;
                wait_cnt_q <= WAIT_LOAD;
              end else begin
                state_q   <= ST_ACCESS;
                sram_en_q <= 1'b1;
                sram_we_q <= core_write;
              end
            end else begin
              // MMIO and unmapped requests finish in one cycle; their side
              // effects are registered so they become visible with core_resp.
              state_q <= ST_RESP;
              resp_q  <= 1'b1;
              if (core_read && core_write) begin
                err_q <= 1'b1;
              end
              case (region_d)
                RG_CONSOLE: begin
                  if (core_write) begin
                    console_valid_q <= 1'b1;
                    console_data_q  <= core_wdata[7:0];
                  end
                end
                RG_HALT: begin
                  if (core_write) begin
                    halt_q      <= 1'b1;
                    exit_code_q <= core_wdata;
                  end
                end
                RG_CYCLE: begin
                  if (!core_write) begin
                    rdata_q <= cycle_q;
                  end
                end
                default: begin
                  err_q <= 1'b1;
                  if (!core_write) begin
                    rdata_q <= 32'hDEAD_BEEF;
                  end
                end
              endcase
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q   <= ST_ACCESS;
            sram_en_q <= 1'b1;
            sram_we_q <= write_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end

        ST_ACCESS: begin
          state_q <= ST_RESP;
          resp_q  <= 1'b1;
          if (both_q) begin
            err_q <= 1'b1;
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
          rdata_q <= '0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM read data arrives in the RESP cycle itself, so it bypasses rdata_q.
  assign core_rdata    = (state_q == ST_RESP && region_q == RG_RAM && !write_q) ? sram_rdata : rdata_q;
  assign core_resp     = resp_q;
  assign sram_en       = sram_en_q;
  assign sram_we       = sram_we_q;
  assign sram_addr     = ram_idx_q;
  assign sram_wdata    = wdata_q;
  assign console_valid = console_valid_q;
  assign console_data  = console_data_q;
  assign halt          = halt_q;
  assign exit_code     = exit_code_q;
  assign err           = err_q;

endmodule
